pw_conv_engine: RTL and testbench
=================================

# pw_conv_engine

Parametrised pointwise (1x1) convolution engine for the squeeze stage of the fire modules. It runs one layer per `start` pulse, using a run-time geometry latched at start. It walks filter groups, rows, columns and channel groups, and fetches image words from ping-pong memory and weight/bias words from weight memory. It MACs `CH_PAR` channels × `FILT_PAR` filters per beat and streams finished pixels out through a 2-entry output queue with valid/ready backpressure.

## Interface
- `CH_PAR`, 16, channels per image word / per beat
- `FILT_PAR`, 8, filters computed in parallel
- `DW`, 16, data/weight/bias width, signed fixed point
- `FRAC`, 8, fractional bits of all operands
- `ACCW`, 40, accumulator width, signed
- `AW`, 32, address width

- `clk`  in  1  sole clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle launch; ignored while `busy`
- `cfg_inch`  in  16  input channels
- `cfg_size`  in  8  spatial size (square)
- `cfg_filt`  in  16  output filters
- `cfg_relu`  in  1  apply ReLU to results
- `busy`  out  1  high from cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse at end of layer
- `err`  out  1  valid with `done`: configuration rejected
- `img_rd`  out  1  image read strobe
- `img_addr`  out  AW  image word address
- `img_data`  in  CH_PAR*DW  image word, lane c = channel base+c
- `w_addr`  out  AW  weight word address (valid with `img_rd`)
- `w_data`  in  FILT_PAR*CH_PAR*DW  weights, lane f*CH_PAR+c
- `bias_addr`  out  AW  bias word address (valid with `img_rd`)
- `bias_data`  in  FILT_PAR*DW  biases, lane f
- `out_valid`  out  1  output head valid
- `out_ready`  in  1  consumer accepts head
- `out_data`  out  FILT_PAR*DW  results, lane f = filter base+f
- `out_addr`  out  AW  output word address of head

## Operation
- States: IDLE → (start) → CHECK → RUN → DRAIN → DONE → IDLE.
- CHECK: accept only if `cfg_inch`≠0 and is a multiple of CH_PAR, `cfg_filt`≠0 and is a multiple of FILT_PAR, and `cfg_size`≠0. Otherwise go straight to DONE with `err`=1, with no reads and no outputs.
- Loop order: filter group fg (outermost), row r, column c, channel group cg (innermost).
  - G = cfg_inch/CH_PAR; S = cfg_size.
- Per beat addresses:
  - `img_addr` = cg·S² + r·S + c
  - `w_addr` = fg·G + cg
  - `bias_addr` = fg
- Output address: `out_addr` = fg·S² + r·S + c.
- MAC: sum = Σ_c img[c]·w[f,c], as full 2DW products sign-extended to ACCW.
  - cg=0: acc_f = (bias_f <<< FRAC) + sum.
  - Otherwise: acc_f += sum.
- Result on cg=G−1: y_f = acc_f >>> FRAC (truncating), saturated to [−2^(DW−1), 2^(DW−1)−1]. If `cfg_relu`, negative values become 0. Then push {y, out_addr} into the queue.
- Credit rule: a beat with cg=G−1 issues only if (queue count + last-beats in flight) < 2. Other beats issue freely. `img_rd` is low on stall cycles, and the counters hold.
- After the final beat issues, RUN → DRAIN. DRAIN → DONE when the pipeline and the queue are both empty.
- `start` while busy: ignored. A config change while busy has no effect, because config is latched at start.
- Reset mid-layer: all state clears immediately and no `done` is produced.

## Timing
- Reset values: `busy`, `done`, `err`, `img_rd`, `out_valid` = 0; addresses and `out_data` = 0; queue empty; state IDLE.
- Memories return data one cycle after `img_rd` (fixed latency 1). `img_data`, `w_data` and `bias_data` are sampled only in that cycle.
- `start` is sampled at edge k. CHECK runs in cycle k+1, and the first `img_rd` is in cycle k+2.
- Last beat of a pixel issued in cycle t → result enters the queue at the end of t+1 → `out_valid` is high in cycle t+2 (queue was empty).
- The queue head is removed at an edge where `out_valid`&&`out_ready`. Push and pop in the same cycle are allowed.
- With no stalls, throughput is one beat per cycle. Total beats = (cfg_filt/FILT_PAR)·S²·G.
- `done` is high in the cycle after the last output is accepted. `busy` falls in that same cycle.
- With `err`, `done` and `err` pulse in cycle k+2.

## Test plan
- Basic run: CH_PAR=16, FILT_PAR=8, inch=32, S=2, filt=8, all image=1.0 (0x0100), all weights=0.5, bias=0.25, out_ready=1.
  - Required: 8 reads with `img_addr` sequence 0,4,1,5,2,6,3,7.
  - Required: 4 outputs, each lane 0x1040 (16.25), `out_addr` 0..3.
  - Required: first `out_valid` in cycle k+5, `done` in cycle k+12.
- Backpressure: same config with out_ready=0 for 20 cycles.
  - Required: exactly 2 entries queued and `img_rd` low while stalled.
  - Required: after release, all 4 outputs arrive in order with no loss or duplication.
- Saturation/ReLU:
  - Weights 0x7FFF with image 0x7FFF → lanes 0x7FFF.
  - Negated weights with cfg_relu=1 → 0x0000.
  - Negated weights with cfg_relu=0 → 0x8000.
- Multi-group run: inch=64, filt=16, S=3.
  - Required: `w_addr` runs 0..3 for fg=0 and 4..7 for fg=1, and `bias_addr` switches at the fg boundary.
  - Required: `out_addr` for fg=1 starts at 9, and 18 outputs total.
- Bad config: inch=24 → `done`=`err`=1 in cycle k+2, with no `img_rd` and no `out_valid`.
- Reset during RUN and start while busy:
  - `rst` low mid-layer → all outputs return to reset values at once.
  - A second `start` while busy is ignored; one `done` only.

Source files
------------

// File: rtl/pw_conv_engine_if.sv
// pw_conv_engine_if: memory fetch bus and output stream of the pointwise conv engine
interface pw_conv_engine_if #(
    parameter int CH_PAR   = 16,
    parameter int FILT_PAR = 8,
    parameter int DW       = 16,
    parameter int AW       = 32
);
    logic                          img_rd;
    logic [AW-1:0]                 img_addr;
    logic [CH_PAR*DW-1:0]          img_data;
    logic [AW-1:0]                 w_addr;
    logic [FILT_PAR*CH_PAR*DW-1:0] w_data;
    logic [AW-1:0]                 bias_addr;
    logic [FILT_PAR*DW-1:0]        bias_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [FILT_PAR*DW-1:0]        out_data;
    logic [AW-1:0]                 out_addr;

    modport master (
        output img_rd, img_addr, w_addr, bias_addr, out_valid, out_data, out_addr,
        input  img_data, w_data, bias_data, out_ready
    );

    modport slave (
        input  img_rd, img_addr, w_addr, bias_addr, out_valid, out_data, out_addr,
        output img_data, w_data, bias_data, out_ready
    );
endinterface

// File: rtl/pw_conv_engine.sv
// pw_conv_engine: 1x1 convolution engine, CH_PAR x FILT_PAR MACs per beat, 2-entry output queue
module pw_conv_engine #(
    parameter int CH_PAR   = 16,
    parameter int FILT_PAR = 8,
    parameter int DW       = 16,
    parameter int FRAC     = 8,
    parameter int ACCW     = 40,
    parameter int AW       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cfg_inch,
    input  logic [7:0]  cfg_size,
    input  logic [15:0] cfg_filt,
    input  logic        cfg_relu,
    output logic        busy,
    output logic        done,
    output logic        err,
    pw_conv_engine_if.master bus
);
    localparam int CS = $clog2(CH_PAR);
    localparam int FS = $clog2(FILT_PAR);
    localparam logic signed [ACCW-1:0] YMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] YMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, DONE} state_t;

    state_t                 state, nxt;
    logic [AW-1:0]          g_r, s2_r, nfg_r;
    logic                   ok_r, err_r, relu_r;
    logic [AW-1:0]          cg, cg_off, pix, fg, fg_off, w_base;
    logic                   last_cg, last_pix, last_fg, issue, push, pop;
    logic                   p_v, p_first, p_last;
    logic [AW-1:0]          p_addr;
    logic signed [ACCW-1:0] acc [FILT_PAR];
    logic signed [ACCW-1:0] acc_n [FILT_PAR];
    logic signed [ACCW-1:0] sum, sh;
    logic signed [2*DW-1:0] prod;
    logic [FILT_PAR*DW-1:0] y;
    logic [FILT_PAR*DW-1:0] q_data [2];
    logic [AW-1:0]          q_addr [2];
    logic                   wp, rp;
    logic [1:0]             cnt;

    assign last_cg  = cg == g_r - AW'(1);
    assign last_pix = pix == s2_r - AW'(1);
    assign last_fg  = fg == nfg_r - AW'(1);
    assign push     = p_v && p_last;
    assign pop      = bus.out_valid && bus.out_ready;
    // a pixel-closing beat needs a free queue slot counting the one already in flight
    assign issue    = state == RUN && (!last_cg || (cnt + {1'b0, push}) < 2'd2);

    assign bus.img_rd    = issue;
    assign bus.img_addr  = cg_off + pix;
    assign bus.w_addr    = w_base + cg;
    assign bus.bias_addr = fg;
    assign bus.out_valid = cnt != 2'd0;
    assign bus.out_data  = q_data[rp];
    assign bus.out_addr  = q_addr[rp];

    assign busy = state == CHECK || state == RUN || state == DRAIN;
    assign done = state == DONE;
    assign err  = done && err_r;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // next-state: drain finishes once nothing is in flight and the queue empties this edge
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = start ? CHECK : IDLE;
            CHECK:   nxt = ok_r ? RUN : DONE;
            RUN:     nxt = (issue && last_cg && last_pix && last_fg) ? DRAIN : RUN;
            DRAIN:   nxt = (!p_v && (cnt == 2'd0 || (cnt == 2'd1 && pop))) ? DONE : DRAIN;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // latch geometry at start so later cfg changes cannot disturb a running layer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_r    <= '0;
            s2_r   <= '0;
            nfg_r  <= '0;
            relu_r <= 1'b0;
            ok_r   <= 1'b0;
            err_r  <= 1'b0;
        end else if (state == IDLE && start) begin
            g_r    <= AW'(cfg_inch >> CS);
            s2_r   <= AW'(cfg_size) * AW'(cfg_size);
            nfg_r  <= AW'(cfg_filt >> FS);
            relu_r <= cfg_relu;
            ok_r   <= cfg_inch != '0 && (cfg_inch & 16'(CH_PAR - 1)) == '0 &&
                      cfg_filt != '0 && (cfg_filt & 16'(FILT_PAR - 1)) == '0 && cfg_size != '0;
        end else if (state == CHECK) begin
            err_r  <= !ok_r;
        end
    end

    // loop counters kept as running address offsets: cg innermost, then pixel, then filter group
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || (state == IDLE && start)) begin
            cg     <= '0;
            cg_off <= '0;
            pix    <= '0;
            fg     <= '0;
            fg_off <= '0;
            w_base <= '0;
        end else if (issue) begin
            if (!last_cg) begin
                cg     <= cg + AW'(1);
                cg_off <= cg_off + s2_r;
            end else begin
                cg     <= '0;
                cg_off <= '0;
                if (!last_pix) begin
                    pix <= pix + AW'(1);
                end else begin
                    pix    <= '0;
                    fg     <= fg + AW'(1);
                    fg_off <= fg_off + s2_r;
                    w_base <= w_base + g_r;
                end
            end
        end
    end

    // beat tag travels alongside the one-cycle memory latency; accumulator updates on returning data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_v     <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
            p_addr  <= '0;
            for (int f = 0; f < FILT_PAR; f++) acc[f] <= '0;
        end else begin
            p_v <= issue;
            if (issue) begin
                p_first <= cg == '0;
                p_last  <= last_cg;
                p_addr  <= fg_off + pix;
            end
            if (p_v) for (int f = 0; f < FILT_PAR; f++) acc[f] <= acc_n[f];
        end
    end

    // MAC over the returned word, then truncate, saturate and optionally rectify
    always_comb begin
        sum  = '0;
        sh   = '0;
        prod = '0;
        y    = '0;
        for (int f = 0; f < FILT_PAR; f++) begin
            sum = '0;
            for (int c = 0; c < CH_PAR; c++) begin
                prod = $signed(bus.img_data[c*DW +: DW]) * $signed(bus.w_data[(f*CH_PAR+c)*DW +: DW]);
                sum  = sum + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
            end
            acc_n[f] = (p_first ? {{(ACCW-DW-FRAC){bus.bias_data[f*DW+DW-1]}}, bus.bias_data[f*DW +: DW], {FRAC{1'b0}}}
                                : acc[f]) + sum;
            sh = acc_n[f] >>> FRAC;
            y[f*DW +: DW] = (relu_r && sh[ACCW-1]) ? '0 :
                            sh > YMAX ? {1'b0, {(DW-1){1'b1}}} :
                            sh < YMIN ? {1'b1, {(DW-1){1'b0}}} : sh[DW-1:0];
        end
    end

    // two-entry output queue with simultaneous push and pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= '0;
            for (int i = 0; i < 2; i++) begin
                q_data[i] <= '0;
                q_addr[i] <= '0;
            end
        end else begin
            if (push) begin
                q_data[wp] <= y;
                q_addr[wp] <= p_addr;
                wp         <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_pw_conv_engine.sv
// tb_pw_conv_engine: directed checks of the pointwise conv engine
module tb_pw_conv_engine;
    localparam int CP = 16;
    localparam int FP = 8;
    localparam int DW = 16;
    localparam int AW = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_inch = '0;
    logic [7:0]  cfg_size = '0;
    logic [15:0] cfg_filt = '0;
    logic        cfg_relu = 1'b0;
    logic        busy, done, err;

    pw_conv_engine_if #(.CH_PAR(CP), .FILT_PAR(FP), .DW(DW), .AW(AW)) bus ();

    pw_conv_engine dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_inch (cfg_inch),
        .cfg_size (cfg_size),
        .cfg_filt (cfg_filt),
        .cfg_relu (cfg_relu),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int kc = 0;
    int first_v, done_n, done_rel;
    logic err_v;
    logic [AW-1:0]    rd_img [$];
    logic [AW-1:0]    rd_w [$];
    logic [AW-1:0]    rd_b [$];
    logic [AW-1:0]    oa [$];
    logic [FP*DW-1:0] od [$];
    logic [FP*DW-1:0] ey;
    logic [AW-1:0]    exp_rd [8] = '{0, 4, 1, 5, 2, 6, 3, 7};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.img_rd) begin
            rd_img.push_back(bus.img_addr);
            rd_w.push_back(bus.w_addr);
            rd_b.push_back(bus.bias_addr);
        end
        if (bus.out_valid && first_v < 0) first_v = cyc - kc;
        if (bus.out_valid && bus.out_ready) begin
            oa.push_back(bus.out_addr);
            od.push_back(bus.out_data);
        end
        if (done) begin
            done_n++;
            done_rel = cyc - kc;
            err_v = err;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear();
        rd_img.delete();
        rd_w.delete();
        rd_b.delete();
        oa.delete();
        od.delete();
        first_v  = -1;
        done_n   = 0;
        done_rel = -1;
        err_v    = 1'b0;
    endtask

    task automatic set_data(input logic [15:0] iv, input logic [15:0] wv, input logic [15:0] bv);
        bus.img_data  = {CP{iv}};
        bus.w_data    = {(FP*CP){wv}};
        bus.bias_data = {FP{bv}};
    endtask

    task automatic launch(input logic [15:0] inch, input logic [7:0] sz, input logic [15:0] filt, input logic relu);
        cfg_inch = inch;
        cfg_size = sz;
        cfg_filt = filt;
        cfg_relu = relu;
        clear();
        start = 1'b1;
        kc = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (done_n == 0 && n < lim) begin
            tick(1);
            n++;
        end
        tick(2);
    endtask

    task automatic check_basic_outs(input string tag);
        chk({tag, "_out_n"}, oa.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_out_addr"}, i < oa.size() ? oa[i] : 'x, i);
            chk({tag, "_out_data"}, i < od.size() ? od[i] : 'x, {FP{16'h1040}});
        end
    endtask

    initial begin
        bus.img_data  = '0;
        bus.w_data    = '0;
        bus.bias_data = '0;
        bus.out_ready = 1'b1;
        clear();
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_img_rd", bus.img_rd, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_img_addr", bus.img_addr, 0);
        chk("rst_w_addr", bus.w_addr, 0);
        chk("rst_out_data", bus.out_data, 0);
        rst = 1'b1;
        tick(2);

        set_data(16'h0100, 16'h0080, 16'h0040);
        launch(32, 2, 8, 0);
        wait_done(100);
        chk("basic_rd_n", rd_img.size(), 8);
        for (int i = 0; i < 8; i++) chk("basic_rd_addr", i < rd_img.size() ? rd_img[i] : 'x, exp_rd[i]);
        check_basic_outs("basic");
        chk("basic_first_valid", first_v, 5);
        chk("basic_done_cycle", done_rel, 12);
        chk("basic_done_n", done_n, 1);
        chk("basic_err", err_v, 0);
        chk("basic_idle_busy", busy, 0);

        bus.out_ready = 1'b0;
        launch(32, 2, 8, 0);
        tick(20);
        chk("bp_rd_n", rd_img.size(), 5);
        chk("bp_img_rd", bus.img_rd, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_busy", busy, 1);
        chk("bp_head_addr", bus.out_addr, 0);
        bus.out_ready = 1'b1;
        wait_done(100);
        chk("bp_rd_total", rd_img.size(), 8);
        check_basic_outs("bp");

        set_data(16'h7fff, 16'h7fff, 16'h0000);
        launch(16, 1, 8, 0);
        wait_done(50);
        chk("sat_pos", od.size() > 0 ? od[0] : 'x, {FP{16'h7fff}});
        set_data(16'h7fff, 16'h8001, 16'h0000);
        launch(16, 1, 8, 1);
        wait_done(50);
        chk("relu_neg", od.size() > 0 ? od[0] : 'x, {FP{16'h0000}});
        launch(16, 1, 8, 0);
        wait_done(50);
        chk("sat_neg", od.size() > 0 ? od[0] : 'x, {FP{16'h8000}});

        for (int c = 0; c < CP; c++) bus.img_data[c*DW +: DW] = 16'(c * 256);
        for (int f = 0; f < FP; f++) begin
            for (int c = 0; c < CP; c++) bus.w_data[(f*CP+c)*DW +: DW] = (c == f) ? 16'h0100 : 16'h0000;
            bus.bias_data[f*DW +: DW] = 16'(f * 16);
            ey[f*DW +: DW] = 16'(f * 16'h0110);
        end
        launch(16, 1, 8, 0);
        wait_done(50);
        chk("lane_map", od.size() > 0 ? od[0] : 'x, ey);

        set_data(16'h0100, 16'h0080, 16'h0040);
        launch(64, 3, 16, 0);
        wait_done(300);
        chk("multi_rd_n", rd_img.size(), 72);
        for (int i = 0; i < 4; i++) begin
            chk("multi_w_fg0", i < rd_w.size() ? rd_w[i] : 'x, i);
            chk("multi_w_fg1", 36 + i < rd_w.size() ? rd_w[36+i] : 'x, 4 + i);
        end
        chk("multi_bias_fg0", rd_b.size() > 35 ? rd_b[35] : 'x, 0);
        chk("multi_bias_fg1", rd_b.size() > 36 ? rd_b[36] : 'x, 1);
        chk("multi_img_cg1", rd_img.size() > 1 ? rd_img[1] : 'x, 9);
        chk("multi_img_cg3", rd_img.size() > 3 ? rd_img[3] : 'x, 27);
        chk("multi_img_pix1", rd_img.size() > 4 ? rd_img[4] : 'x, 1);
        chk("multi_out_n", oa.size(), 18);
        chk("multi_out_fg1", oa.size() > 9 ? oa[9] : 'x, 9);
        chk("multi_out_last", oa.size() > 17 ? oa[17] : 'x, 17);
        chk("multi_out_data", od.size() > 17 ? od[17] : 'x, {FP{16'h2040}});
        chk("multi_done_n", done_n, 1);

        launch(24, 2, 8, 0);
        wait_done(20);
        chk("bad_done_cycle", done_rel, 2);
        chk("bad_err", err_v, 1);
        chk("bad_rd_n", rd_img.size(), 0);
        chk("bad_no_valid", first_v, -1);
        launch(32, 2, 12, 0);
        wait_done(20);
        chk("bad_filt_err", err_v, 1);
        launch(32, 0, 8, 0);
        wait_done(20);
        chk("bad_size_err", err_v, 1);

        launch(32, 2, 8, 0);
        tick(2);
        cfg_inch = 64;
        cfg_size = 3;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(100);
        tick(10);
        chk("busy_start_done_n", done_n, 1);
        chk("busy_start_rd_n", rd_img.size(), 8);
        check_basic_outs("busy_start");

        launch(32, 2, 8, 0);
        tick(4);
        chk("mid_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_img_rd", bus.img_rd, 0);
        chk("mid_rst_img_addr", bus.img_addr, 0);
        chk("mid_rst_bias_addr", bus.bias_addr, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_data", bus.out_data, 0);
        tick(2);
        rst = 1'b1;
        clear();
        tick(20);
        chk("mid_rst_no_done", done_n, 0);
        chk("mid_rst_no_rd", rd_img.size(), 0);

        launch(32, 2, 8, 0);
        wait_done(100);
        check_basic_outs("recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
